// File: rtl/mod_addsub_pipe.sv
// Pipelined modular adder/subtractor: r = (a +/- b) mod q.
// Two register stages with valid/ready flow control. Both adders are
// segmented carry-lookahead adders; segment carries combine group P/G terms.
module mod_addsub_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEG_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] q_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r_out,
  output logic             range_err
);

  localparam int unsigned NumSeg = WIDTH / SEG_WIDTH;

  // Segmented carry-lookahead add: returns {carry_out, sum}.
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             cin);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] s;
    logic [NumSeg:0]  sc;
    logic             grp_g;
    logic             grp_p;
    logic             c;
    g     = x & y;
    p     = x ^ y;
    s     = '0;
    sc    = '0;
    sc[0] = cin;
    // Group generate/propagate per segment, then segment carry-ins.
    for (int k = 0; k < int'(NumSeg); k++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < int'(SEG_WIDTH); i++) begin
        grp_g = g[k*SEG_WIDTH+i] | (p[k*SEG_WIDTH+i] & grp_g);
        grp_p = grp_p & p[k*SEG_WIDTH+i];
      end
      sc[k+1] = grp_g | (grp_p & sc[k]);
    end
    // Bit carries inside each segment expand from that segment's carry-in.
    for (int k = 0; k < int'(NumSeg); k++) begin
      for (int i = 0; i < int'(SEG_WIDTH); i++) begin
        c = sc[k];
        for (int j = 0; j < i; j++) begin
          c = g[k*SEG_WIDTH+j] | (p[k*SEG_WIDTH+j] & c);
        end
        s[k*SEG_WIDTH+i] = p[k*SEG_WIDTH+i] ^ c;
      end
    end
    return {sc[NumSeg], s};
  endfunction

  // Stage 1 registers
  logic             s1_valid;
  logic [WIDTH:0]   s1_raw;
  logic [WIDTH-1:0] s1_q;
  logic             s1_mode;
  logic             s1_err;

  // Handshake enables
  logic s1_en;
  logic s2_en;

  // Stage 1 combinational results
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   raw_d;
  logic             err_d;

  // Stage 2 combinational results
  logic [WIDTH-1:0] corr;
  logic [WIDTH:0]   sum2;
  logic             use_sum2;
  logic [WIDTH-1:0] r_d;

  // Stage advance whenever the next slot is free or draining this cycle.
  always_comb begin
    s2_en    = !out_valid | out_ready;
    s1_en    = !s1_valid | s2_en;
    in_ready = s1_en;
  end

  // Stage 1: raw sum/difference with carry-out, and operand range check.
  always_comb begin
    b_op  = mode ? ~b_in : b_in;
    raw_d = cla_add(a_in, b_op, mode);
    err_d = (a_in >= q_in) | (b_in >= q_in);
  end

  // Stage 2: one adder serves both corrections. Add mode computes raw - q
  // (its carry-out means raw_low >= q); sub mode computes raw + q.
  always_comb begin
    corr = s1_mode ? s1_q : ~s1_q;
    sum2 = cla_add(s1_raw[WIDTH-1:0], corr, ~s1_mode);
    if (s1_mode) begin
      use_sum2 = ~s1_raw[WIDTH];
    end else begin
      use_sum2 = s1_raw[WIDTH] | sum2[WIDTH];
    end
    r_d = use_sum2 ? sum2[WIDTH-1:0] : s1_raw[WIDTH-1:0];
  end

  // Stage 1 register: capture an accepted beat, drop valid when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s1_q     <= '0;
      s1_mode  <= 1'b0;
      s1_err   <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_raw  <= raw_d;
        s1_q    <= q_in;
        s1_mode <= mode;
        s1_err  <= err_d;
      end
    end
  end

  // Stage 2 / output register: holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      r_out     <= '0;
      range_err <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        r_out     <= r_d;
        range_err <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: vector table, streaming,
// backpressure, reset flush and a randomised stall run, all scoreboarded.
module tb_mod_addsub_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] q_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r_out;
  logic         range_err;

  mod_addsub_pipe #(.WIDTH(32), .SEG_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a_in      (a_in),
    .b_in      (b_in),
    .q_in      (q_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_out     (r_out),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         err;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   out_count = 0;
  exp_t sbq[$];

  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_r;
  logic         hold_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] q);
    exp_t        e;
    logic [63:0] t;
    e.err = (a >= q) || (b >= q);
    if (m) t = ({32'd0, a} + {32'd0, q} - {32'd0, b}) % {32'd0, q};
    else   t = ({32'd0, a} + {32'd0, b}) % {32'd0, q};
    e.r = t[W-1:0];
    return e;
  endfunction

  // Output monitor: pops on each handshake, and checks that a stalled beat holds.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_r", r_out, hold_r);
        check("hold_err", range_err, hold_err);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got r=%0h with no beat pending", r_out);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("range_err", range_err, e.err);
          if (!e.err) check("r_out", r_out, e.r);
          out_count++;
        end
      end
      hold_pend <= out_valid && !out_ready;
      hold_r    <= r_out;
      hold_err  <= range_err;
    end
  end

  // Drive one beat; returns the number of stall cycles seen before acceptance.
  task automatic send(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input exp_t e, output int stalls);
    in_valid = 1'b1;
    mode = m;
    a_in = a;
    b_in = b;
    q_in = q;
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 200) begin
      @(negedge clk);
      stalls++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
    end else begin
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", sbq.size(), 0);
  endtask

  vec_t vecs[12];
  bit   stop_rdy = 1'b0;

  initial begin
    int   st;
    int   total_st;
    int   oc;
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rq;
    logic [W-1:0] held;

    vecs[0]  = '{1'b0, 32'hFFFFFFFA, 32'h2,        32'hFFFFFFFB, 32'h1,        1'b0};
    vecs[1]  = '{1'b1, 32'h1,        32'h3,        32'hFFFFFFFB, 32'hFFFFFFF9, 1'b0};
    vecs[2]  = '{1'b1, 32'h5,        32'h5,        32'hFFFFFFFB, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'd20,       32'd1,        32'd17,       32'h0,        1'b1};
    vecs[4]  = '{1'b0, 32'd16,       32'd16,       32'd17,       32'd15,       1'b0};
    vecs[5]  = '{1'b0, 32'h0,        32'h0,        32'hFFFFFFFB, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFB, 32'hFFFFFFF9, 1'b0};
    vecs[7]  = '{1'b0, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h1,        1'b0};
    vecs[8]  = '{1'b1, 32'd0,        32'd16,       32'd17,       32'd1,        1'b0};
    vecs[9]  = '{1'b0, 32'd5,        32'd17,       32'd17,       32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'd1,        32'd1,        32'd2,        32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'h999,      32'h0,        32'h1000,     32'h999,      1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    mode = 1'b0;
    a_in = '0;
    b_in = '0;
    q_in = 32'd2;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_r_out", r_out, 32'h0);
    check("reset_range_err", range_err, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);

    // Latency: single beat into an idle pipe shows up after the second edge.
    e.r = 32'h1;
    e.err = 1'b0;
    send(1'b0, 32'hFFFFFFFA, 32'h2, 32'hFFFFFFFB, e, st);
    check("lat_not_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_valid", out_valid, 1'b1);
    drain();

    // Vector table, back-to-back.
    for (int i = 0; i < 12; i++) begin
      e.r = vecs[i].r;
      e.err = vecs[i].err;
      send(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].q, e, st);
    end
    drain();

    // Streaming: 8 beats with no stall expected.
    total_st = 0;
    oc = out_count;
    for (int i = 0; i < 8; i++) begin
      rq = $urandom;
      if (rq < 2) rq = 32'd2;
      ra = $urandom % rq;
      rb = $urandom % rq;
      send(i[0], ra, rb, rq, model(i[0], ra, rb, rq), st);
      total_st += st;
    end
    check("stream_stalls", total_st, 0);
    drain();
    check("stream_count", out_count - oc, 8);

    // Backpressure: two beats in flight, consumer stalls 3 cycles.
    out_ready = 1'b0;
    oc = out_count;
    send(1'b0, 32'd10, 32'd9, 32'd17, model(1'b0, 32'd10, 32'd9, 32'd17), st);
    send(1'b1, 32'd3, 32'd9, 32'd17, model(1'b1, 32'd3, 32'd9, 32'd17), st);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    held = r_out;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_in_ready_hold", in_ready, 1'b0);
      check("bp_r_stable", r_out, held);
    end
    out_ready = 1'b1;
    drain();
    check("bp_count", out_count - oc, 2);

    // Reset with two beats in flight: both are discarded.
    out_ready = 1'b0;
    send(1'b0, 32'd1, 32'd2, 32'd17, model(1'b0, 32'd1, 32'd2, 32'd17), st);
    send(1'b0, 32'd3, 32'd4, 32'd17, model(1'b0, 32'd3, 32'd4, 32'd17), st);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    out_ready = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    oc = out_count;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_emit", out_count - oc, 0);

    // Random traffic with random consumer stalls.
    oc = out_count;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic m;
          m  = 1'($urandom_range(0, 1));
          rq = $urandom_range(2, 1000);
          ra = (i % 10 == 3) ? rq + 32'd1 : $urandom % rq;
          rb = $urandom % rq;
          send(m, ra, rb, rq, model(m, ra, rb, rq), st);
        end
        stop_rdy = 1'b1;
      end
      begin
        while (!stop_rdy) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("rand_count", out_count - oc, 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
